// File: rtl/busy_dram_pkg.sv
// Shared definitions for the DRAM request-port arbiter.
//   DEF_ABITS / DEF_DBITS : default DRAM word address / data widths
//   arb_t                 : arbiter FSM states
//   REQ_TM / REQ_SCAN     : requester indices (tape engine, dump scanner)
package busy_dram_pkg;

    localparam int DEF_ABITS = 18;
    localparam int DEF_DBITS = 4;

    localparam logic REQ_TM   = 1'b0;
    localparam logic REQ_SCAN = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin chooser with lock override.
//   req        : request vector, bit i = requester i
//   last       : index of the most recent owner
//   lock_valid : a lock is active for lock_owner
//   lock_owner : requester that holds the lock
//   valid      : at least one requester is asking
//   sel        : chosen requester (meaningful only when valid)
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = |req;
        // Tie (or no request): favour whoever did not go last.
        sel   = ~last;
        if (lock_valid && req[lock_owner]) begin
            sel = lock_owner;
        end else if (req == 2'b01) begin
            sel = 1'b0;
        end else if (req == 2'b10) begin
            sel = 1'b1;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single page-mode DRAM controller request port between the
// tape engine (requester 0) and the dump/display scanner (requester 1).
// Round-robin with a bounded lock for atomic read-modify-write pairs,
// gating while the controller is busy, and a sticky hung-controller flag.
//   clk, rst                       : clock, asynchronous active-high reset
//   rN_req/write/lock/addr/wdata   : requester N transaction (held until done)
//   rN_done                        : one-cycle completion pulse to requester N
//   rdata                          : last read data, held until next completion
//   m_ena/write/addr/wdata         : request to the DRAM controller
//   m_rdata, m_busy, m_ack         : controller response
//   grant                          : current or most recent owner
//   err                            : sticky timeout flag
module dram_arbiter
    import busy_dram_pkg::*;
#(
    parameter int ABITS    = DEF_ABITS,
    parameter int DBITS    = DEF_DBITS,
    parameter int LOCK_MAX = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic             r0_write,
    input  logic             r0_lock,
    input  logic [ABITS-1:0] r0_addr,
    input  logic [DBITS-1:0] r0_wdata,
    output logic             r0_done,
    input  logic             r1_req,
    input  logic             r1_write,
    input  logic             r1_lock,
    input  logic [ABITS-1:0] r1_addr,
    input  logic [DBITS-1:0] r1_wdata,
    output logic             r1_done,
    output logic [DBITS-1:0] rdata,
    output logic             m_ena,
    output logic             m_write,
    output logic [ABITS-1:0] m_addr,
    output logic [DBITS-1:0] m_wdata,
    input  logic [DBITS-1:0] m_rdata,
    input  logic             m_busy,
    input  logic             m_ack,
    output logic             grant,
    output logic             err
);

    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [LCW-1:0] LOCK_MAX_C = LCW'(LOCK_MAX);
    localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT);

    arb_t             state_q, state_d;
    logic             grant_q, grant_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             m_ena_q, m_ena_d;
    logic             m_write_q, m_write_d;
    logic [ABITS-1:0] m_addr_q, m_addr_d;
    logic [DBITS-1:0] m_wdata_q, m_wdata_d;
    logic [DBITS-1:0] rdata_q, rdata_d;
    logic [1:0]       done_q, done_d;

    logic [1:0] req_vec;
    logic       lock_valid;
    logic       pick_valid;
    logic       pick_sel;
    logic       pick_write;
    logic       pick_lock;
    logic [ABITS-1:0] pick_addr;
    logic [DBITS-1:0] pick_wdata;

    assign req_vec = {r1_req, r0_req};
    // A count of LOCK_MAX means the lock is spent: next pick is pure round-robin.
    assign lock_valid = (lock_cnt_q != '0) && (lock_cnt_q < LOCK_MAX_C);

    rr_pick2 u_pick (
        .req        (req_vec),
        .last       (grant_q),
        .lock_valid (lock_valid),
        .lock_owner (grant_q),
        .valid      (pick_valid),
        .sel        (pick_sel)
    );

    assign pick_write = pick_sel ? r1_write : r0_write;
    assign pick_lock  = pick_sel ? r1_lock  : r0_lock;
    assign pick_addr  = pick_sel ? r1_addr  : r0_addr;
    assign pick_wdata = pick_sel ? r1_wdata : r0_wdata;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        lock_cnt_d = lock_cnt_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        m_ena_d    = m_ena_q;
        m_write_d  = m_write_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        rdata_d    = rdata_q;
        done_d     = 2'b00;

        case (state_q)
            ARB_IDLE: begin
                if (!m_busy && pick_valid) begin
                    grant_d   = pick_sel;
                    m_write_d = pick_write;
                    m_addr_d  = pick_addr;
                    m_wdata_d = pick_wdata;
                    m_ena_d   = 1'b1;
                    tmo_d     = '0;
                    state_d   = ARB_ISSUE;
                    // A change of owner starts its lock run from zero.
                    if (lock_cnt_q >= LOCK_MAX_C) begin
                        lock_cnt_d = '0;
                    end else if (pick_lock) begin
                        lock_cnt_d = ((pick_sel == grant_q) ? lock_cnt_q : '0) + LCW'(1);
                    end else begin
                        lock_cnt_d = '0;
                    end
                end else if (lock_cnt_q != '0 && !req_vec[grant_q]) begin
                    // Locked owner walked away: release the lock.
                    lock_cnt_d = '0;
                end
            end

            ARB_ISSUE, ARB_WAIT: begin
                if (tmo_q == TMO_LAST) begin
                    // Hung controller: abandon silently, requesters get no done.
                    err_d      = 1'b1;
                    m_ena_d    = 1'b0;
                    lock_cnt_d = '0;
                    state_d    = ARB_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (state_q == ARB_ISSUE) begin
                        if (m_ack) begin
                            m_ena_d = 1'b0;
                            state_d = ARB_WAIT;
                        end
                    end else if (!m_busy) begin
                        if (!m_write_q) begin
                            rdata_d = m_rdata;
                        end
                        done_d[grant_q] = 1'b1;
                        state_d         = ARB_DONE;
                    end
                end
            end

            ARB_DONE: begin
                // Gap cycle so the owner can drop req or load its next fields.
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= REQ_SCAN;
            lock_cnt_q <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            m_ena_q    <= 1'b0;
            m_write_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            rdata_q    <= '0;
            done_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            lock_cnt_q <= lock_cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            m_ena_q    <= m_ena_d;
            m_write_q  <= m_write_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
        end
    end

    assign r0_done = done_q[REQ_TM];
    assign r1_done = done_q[REQ_SCAN];
    assign rdata   = rdata_q;
    assign m_ena   = m_ena_q;
    assign m_write = m_write_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign grant   = grant_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: a behavioural DRAM controller,
// a reference memory and an arbitration-order model.
module tb_dram_arbiter;

    localparam int AB   = 18;
    localparam int DB   = 4;
    localparam int LMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r0_write, r0_lock, r0_done;
    logic [AB-1:0] r0_addr;
    logic [DB-1:0] r0_wdata;
    logic          r1_req, r1_write, r1_lock, r1_done;
    logic [AB-1:0] r1_addr;
    logic [DB-1:0] r1_wdata;
    logic [DB-1:0] rdata, m_wdata, m_rdata;
    logic [AB-1:0] m_addr;
    logic          m_ena, m_write, m_busy, m_ack, grant, err;

    dram_arbiter #(.ABITS(AB), .DBITS(DB), .LOCK_MAX(LMAX), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_write(r0_write), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_done(r0_done),
        .r1_req(r1_req), .r1_write(r1_write), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_done(r1_done),
        .rdata(rdata), .m_ena(m_ena), .m_write(m_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_busy(m_busy), .m_ack(m_ack),
        .grant(grant), .err(err)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- behavioural DRAM controller ----------------
    logic [DB-1:0] dram [int];
    bit            init_busy = 1'b1;
    bit            no_ack    = 1'b0;
    int            fix_lat   = 0;
    bit            c_act     = 1'b0;
    logic          c_wr;
    logic [AB-1:0] c_addr;
    logic [DB-1:0] c_wd;
    int            c_cnt;

    function automatic logic [DB-1:0] dram_rd(input int a);
        return dram.exists(a) ? dram[a] : 4'h0;
    endfunction

    initial begin
        m_ack   = 1'b0;
        m_busy  = 1'b1;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            m_ack = 1'b0;
            if (!c_act) begin
                if (m_ena && !no_ack && !init_busy) begin
                    m_ack  = 1'b1;
                    c_act  = 1'b1;
                    c_wr   = m_write;
                    c_addr = m_addr;
                    c_wd   = m_wdata;
                    c_cnt  = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 6));
                end
            end else if (c_cnt > 1) begin
                c_cnt--;
            end else begin
                if (c_wr) dram[int'(c_addr)] = c_wd;
                else      m_rdata = dram_rd(int'(c_addr));
                c_act = 1'b0;
            end
            m_busy = init_busy || c_act;
        end
    end

    // ---------------- done pulse monitor ----------------
    int n_done_mon = 0;
    bit wide_err   = 1'b0;
    bit p0 = 1'b0, p1 = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (r0_done || r1_done) n_done_mon++;
            if ((r0_done && p0) || (r1_done && p1) || (r0_done && r1_done)) wide_err = 1'b1;
            p0 = r0_done;
            p1 = r1_done;
        end
    end

    // ---------------- reference model ----------------
    logic [DB-1:0] ref_mem [int];
    logic [DB-1:0] rdata_exp = '0;
    int            last_m = 1;
    int            lc_m   = 0;
    int            n_txn  = 0;

    function automatic logic [DB-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 4'h0;
    endfunction

    function automatic logic [31:0] pack_outs();
        return {m_ena, m_write, m_addr, m_wdata, r0_done, r1_done, rdata, grant, err};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_m    = 1;
        lc_m      = 0;
        rdata_exp = '0;
    endtask

    task automatic wait_done(output int who);
        int c;
        who = -1;
        c   = 0;
        while (who < 0 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
            if (r0_done && r1_done) who = 2;
            else if (r0_done)       who = 0;
            else if (r1_done)       who = 1;
        end
        if (who < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_txn(input string tag, input int who, input int exp_who,
                              input logic wr, input logic [AB-1:0] a, input logic [DB-1:0] d);
        if (wr) ref_mem[int'(a)] = d;
        else    rdata_exp = ref_rd(int'(a));
        $display("txn %s: owner=%0d exp=%0d wr=%0d addr=%0h rdata=%0h exp_rdata=%0h",
                 tag, who, exp_who, wr, a, rdata, rdata_exp);
        check({tag, "_owner"}, who, exp_who);
        check({tag, "_grant"}, {31'b0, grant}, exp_who);
        check({tag, "_rdata"}, {28'b0, rdata}, {28'b0, rdata_exp});
        last_m = exp_who;
        n_txn++;
    endtask

    task automatic rand_fields(input int side, input int mode);
        logic [AB-1:0] a;
        logic          wr, lk;
        logic [DB-1:0] d;
        a  = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : AB'($urandom_range(0, 7));
        wr = 1'($urandom_range(0, 1));
        d  = DB'($urandom);
        lk = (mode == 0) ? 1'($urandom_range(0, 1)) : ((mode == 1) ? (side == 0) : 1'b0);
        if (side == 0) begin
            r0_addr = a; r0_write = wr; r0_wdata = d; r0_lock = lk;
        end else begin
            r1_addr = a; r1_write = wr; r1_wdata = d; r1_lock = lk;
        end
    endtask

    // Both requesters ask continuously; winners follow the round-robin/lock rules.
    task automatic run_both(input int n, input int mode, input string tag);
        int w, who;
        logic wr_s, lk;
        logic [AB-1:0] a_s;
        logic [DB-1:0] d_s;
        do_reset();
        rand_fields(0, mode);
        rand_fields(1, mode);
        r0_req = 1'b1;
        r1_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (lc_m > 0 && lc_m < LMAX) w = last_m;
            else                         w = 1 - last_m;
            lk   = (w == 1) ? r1_lock  : r0_lock;
            wr_s = (w == 1) ? r1_write : r0_write;
            a_s  = (w == 1) ? r1_addr  : r0_addr;
            d_s  = (w == 1) ? r1_wdata : r0_wdata;
            lc_m = (lc_m < LMAX && lk) ? lc_m + 1 : 0;
            wait_done(who);
            finish_txn(tag, who, w, wr_s, a_s, d_s);
            if (k == n - 1) begin
                if (w == 1) r1_req = 1'b0;
                else        r0_req = 1'b0;
            end else begin
                rand_fields(w, mode);
            end
        end
        // The other requester is still pending and is now the sole asker.
        w    = 1 - last_m;
        wr_s = (w == 1) ? r1_write : r0_write;
        a_s  = (w == 1) ? r1_addr  : r0_addr;
        d_s  = (w == 1) ? r1_wdata : r0_wdata;
        wait_done(who);
        finish_txn({tag, "_drain"}, who, w, wr_s, a_s, d_s);
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  who, cyc;
        bit  seen;
        rst = 1'b1;
        r0_req = 0; r0_write = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_write = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
        dram[5] = 4'hA;
        ref_mem[5] = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", pack_outs(), 32'h2);
        @(negedge clk);
        rst = 1'b0;

        // Init gating: controller busy for 100 cycles with a pending read.
        r0_write = 0; r0_addr = 18'd5; r0_lock = 0; r0_req = 1;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (m_ena) seen = 1;
        end
        check("init_gate", {31'b0, seen}, 0);
        init_busy = 0;
        wait_done(who);
        finish_txn("init_rd", who, 0, 1'b0, 18'd5, 4'h0);
        r0_req = 0;

        // Simultaneous rise: r0 write 3 @0x10, r1 read @0x10.
        do_reset();
        r0_write = 1; r0_addr = 18'h10; r0_wdata = 4'h3; r0_lock = 0;
        r1_write = 0; r1_addr = 18'h10; r1_wdata = 4'h0; r1_lock = 0;
        r0_req = 1; r1_req = 1;
        wait_done(who);
        finish_txn("tie_r0", who, 0, 1'b1, 18'h10, 4'h3);
        r0_req = 0;
        wait_done(who);
        finish_txn("tie_r1", who, 1, 1'b0, 18'h10, 4'h0);
        r1_req = 0;

        run_both(10, 1, "lock");
        run_both(8, 2, "alt");
        run_both(60, 0, "rand");

        // Read-modify-write pair at the top address with r1 hammering.
        do_reset();
        r0_write = 0; r0_addr = 18'h3FFFF; r0_lock = 1;
        r1_write = 0; r1_addr = 18'h3FFFF; r1_lock = 0;
        r0_req = 1; r1_req = 1;
        wait_done(who);
        finish_txn("rmw_rd", who, 0, 1'b0, 18'h3FFFF, 4'h0);
        r0_write = 1; r0_wdata = 4'h2; r0_lock = 0;
        wait_done(who);
        finish_txn("rmw_wr", who, 0, 1'b1, 18'h3FFFF, 4'h2);
        r0_req = 0;
        wait_done(who);
        finish_txn("rmw_r1", who, 1, 1'b0, 18'h3FFFF, 4'h0);
        r1_req = 0;
        check("rmw_mem", {28'b0, dram_rd(32'h3FFFF)}, 32'h2);

        // Hung controller: never acknowledges.
        do_reset();
        no_ack = 1;
        r0_write = 0; r0_addr = 18'd5; r0_lock = 0; r0_req = 1;
        cyc = 0; seen = 0;
        while (!err && cyc < 1200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (r0_done || r1_done) seen = 1;
        end
        $display("txn timeout: err=%0d m_ena=%0d cycles=%0d", err, m_ena, cyc);
        check("tmo_err", {31'b0, err}, 1);
        check("tmo_ena", {31'b0, m_ena}, 0);
        check("tmo_nodone", {31'b0, seen}, 0);
        check("tmo_late", {31'b0, (cyc >= 1000)}, 1);
        no_ack = 0;
        wait_done(who);
        finish_txn("tmo_retry", who, 0, 1'b0, 18'd5, 4'h0);
        check("tmo_sticky", {31'b0, err}, 1);
        r0_req = 0;

        // Reset during ISSUE must drop m_ena at once.
        no_ack = 1;
        r0_write = 1; r0_addr = 18'h7; r0_wdata = 4'h9; r0_req = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_issue_ena", {31'b0, m_ena}, 0);
        r0_req = 0;
        no_ack = 0;
        @(negedge clk);
        rst = 1'b0;

        // Read completes (rdata nonzero), then reset during WAIT of the next.
        r0_write = 0; r0_addr = 18'd5; r0_req = 1;
        last_m = 1; lc_m = 0; rdata_exp = '0;
        wait_done(who);
        finish_txn("pre_rst", who, 0, 1'b0, 18'd5, 4'h0);
        fix_lat = 20;
        r0_addr = 18'h3FFFF;
        cyc = 0;
        while (!m_ack && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst_ack_seen", {31'b0, m_ack}, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", pack_outs(), 32'h2);
        r0_req = 0;
        @(negedge clk);
        rst = 1'b0;
        last_m = 1; lc_m = 0; rdata_exp = '0; fix_lat = 0;
        r1_write = 0; r1_addr = 18'h10; r1_lock = 0; r1_req = 1;
        wait_done(who);
        finish_txn("rst_next", who, 1, 1'b0, 18'h10, 4'h0);
        check("rst_err_clr", {31'b0, err}, 0);
        r1_req = 0;

        repeat (5) @(posedge clk);
        #1;
        check("done_width", {31'b0, wide_err}, 0);
        check("done_count", n_done_mon, n_txn);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single 256k x 4 page-mode DRAM controller request port (ena/write/addr, ack/busy handshake) between two requesters.
  - Requester 0: Turing-machine tape engine.
  - Requester 1: tape dump / display scanner.
- Round-robin arbitration with a lock that keeps a read-modify-write pair atomic.
- Also gates all traffic until DRAM init completes and flags a hung controller.
- Sits between the requesters and the DRAM controller in the top level.

Parameters:
- ABITS, 18, DRAM word address width.
- DBITS, 4, DRAM data width.
- LOCK_MAX, 4, max consecutive locked transactions before a forced hand-over.
- TIMEOUT, 1023, cycles allowed in ISSUE or WAIT before err is set.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- r0_req  in  1  requester 0 transaction request; held until r0_done.
- r0_write  in  1  1 = write, 0 = read; stable while r0_req.
- r0_lock  in  1  keep grant after this transaction; sampled at grant.
- r0_addr  in  ABITS  word address; stable while r0_req.
- r0_wdata  in  DBITS  write data; stable while r0_req.
- r0_done  out  1  one-cycle completion pulse.
- r1_req, r1_write, r1_lock, r1_addr, r1_wdata, r1_done  same as requester 0, for requester 1.
- rdata  out  DBITS  read data, valid in the r*_done cycle, held until the next completion.
- m_ena  out  1  controller enable.
- m_write  out  1  controller write select.
- m_addr  out  ABITS  controller address.
- m_wdata  out  DBITS  controller write data.
- m_rdata  in  DBITS  controller read data, valid when m_busy falls.
- m_busy  in  1  controller busy (init, refresh, access).
- m_ack  in  1  controller has accepted the current request.
- grant  out  1  index of the current or most recent owner.
- err  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset values:
  - m_ena, m_write, m_addr, m_wdata = 0.
  - r0_done, r1_done, rdata = 0.
  - grant = 1, so requester 0 wins the first tie.
  - err = 0; lock_cnt = 0; state = IDLE.
- Rst is asynchronous; asserting it mid-transaction drops m_ena immediately. The DRAM controller completes its cycle independently.
- IDLE:
  - Wait while m_busy = 1. This covers power-up init and refresh.
  - When m_busy = 0 and any req is high, pick the owner:
    - If locked (lock_cnt > 0) and the locked owner's req is high, pick that owner.
    - Otherwise use round-robin: prefer the requester that is not the last grant.
    - If only one requester is high, pick it.
  - Register grant, m_addr, m_write and m_wdata from the owner. Set m_ena = 1. Go to ISSUE.
  - The latched lock bit determines lock_cnt:
    - Lock set and lock_cnt < LOCK_MAX: lock_cnt increments.
    - Otherwise lock_cnt = 0.
  - If lock_cnt reaches LOCK_MAX, the next arbitration is pure round-robin and lock_cnt returns to 0.
- ISSUE:
  - Hold m_ena = 1 and the fields stable until m_ack = 1.
  - Then m_ena = 0 on the next edge; go to WAIT.
- WAIT:
  - When m_busy = 0, capture m_rdata into rdata on reads. On writes rdata is unchanged.
  - Pulse the owner's r*_done for exactly one cycle; go to DONE.
- DONE:
  - One cycle, so the requester can drop req or change fields.
  - Return to IDLE. Requester req is not sampled in this cycle.
- Minimum turnaround is 4 clk per transaction plus controller latency. There is no back-to-back issue.
- A locked owner that drops req while in IDLE releases the lock; lock_cnt = 0.
- Timeout: a 10-bit counter runs in ISSUE and WAIT.
  - At TIMEOUT: set err, drop m_ena, return to IDLE with no done pulse, clear lock.
  - Requesters see no completion; err is for the display/debug path.
- A requester dropping req before done is illegal; the behaviour is undefined and the bench must not do it.
- Both requesters rising in the same cycle resolve by round-robin; exactly one done is issued per transaction.
- Address arithmetic is not performed here; requesters own wrap-around.

Decomposition:
- Shared package busy_dram_pkg holds:
  - ABITS and DBITS defaults.
  - arb_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE}.
  - The side constants REQ_TM = 0 and REQ_SCAN = 1.
- One sub-module, rr_pick2:
  - Combinational two-way round-robin chooser.
  - Inputs: req[1:0], last, lock_valid, lock_owner.
  - Outputs: valid, sel.
- FSM, timeout counter and lock counter stay in dram_arbiter.

Test Plan:
- Hold m_busy = 1 for 100 cycles after rst, r0_req = 1 (read, addr 5) -> m_ena stays 0 until m_busy = 0, then one read at addr 5. r0_done pulses once with rdata = model value.
- r0 and r1 requests rise in the same cycle (r0 write 0x3 @ 0x10, r1 read @ 0x10) -> r0 serviced first. r1 then returns rdata = 0x3 and grant = 1.
- r0 continuously requesting with lock = 1, r1 requesting -> exactly LOCK_MAX = 4 r0 transactions, then r1 is granted. With lock = 0, grants alternate 0,1,0,1.
- r0 read @ 0x3FFFF then write newsym 0x2 with lock = 1 while r1 hammers -> r1 gets no access between the pair; the memory model shows 0x2 at 0x3FFFF.
- Controller model never asserts m_ack -> after 1023 cycles err = 1, m_ena = 0, no done. A subsequent serviced request completes normally with err still 1.
- Assert rst during WAIT -> all outputs return to reset values asynchronously; the next request after release is served correctly.
